// File: rtl/task_8_deserializer.sv
// Receive end of the task 8 byte-stream link: gathers NUM_BYTES serial bytes into
// one parallel frame, publishes it with a one-cycle valid pulse, aborts stalled frames.
module task_8_deserializer #(
    parameter int NUM_BYTES   = 16,
    parameter int DATA_W      = 8,
    parameter int GAP_TIMEOUT = 4,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_data [NUM_BYTES],
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_W'(GAP_TIMEOUT - 1) : '0;

    typedef enum logic {
        s_IDLE,
        s_COLLECT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [GAP_W-1:0]  gap;
    logic [GAP_W-1:0]  gap_next;
    logic [DATA_W-1:0] cap_buf [NUM_BYTES];
    logic              capture;
    logic              frame_last;
    logic              abort;
    logic              done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= s_IDLE;
            idx   <= '0;
            gap   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            gap   <= gap_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        gap_next   = gap;
        capture    = 1'b0;
        frame_last = 1'b0;
        abort      = 1'b0;
        case (state)
            s_IDLE: begin
                idx_next = '0;
                gap_next = '0;
                if (i_valid) begin
                    capture    = 1'b1;
                    idx_next   = IDX_W'(1);
                    state_next = s_COLLECT;
                end
            end
            s_COLLECT: begin
                if (i_valid) begin
                    capture  = 1'b1;
                    gap_next = '0;
                    if (idx == LAST_IDX) begin
                        frame_last = 1'b1;
                        idx_next   = '0;
                        state_next = s_IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end else if (GAP_TIMEOUT > 0) begin
                    // The idle cycle that reaches the limit aborts immediately.
                    if (gap == GAP_LAST) begin
                        abort      = 1'b1;
                        idx_next   = '0;
                        gap_next   = '0;
                        state_next = s_IDLE;
                    end else begin
                        gap_next = gap + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_next = s_IDLE;
                idx_next   = '0;
                gap_next   = '0;
            end
        endcase
    end

    // The capture buffer is copied out one cycle after the last byte, so a new
    // frame can overwrite lane 0 on the same edge the old frame is published.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                cap_buf[i] <= '0;
                o_data[i]  <= '0;
            end
            done        <= 1'b0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (capture) begin
                cap_buf[idx] <= i_data;
            end
            done    <= frame_last;
            o_valid <= done;
            o_err   <= abort;
            o_busy  <= (state_next == s_COLLECT);
            if (done) begin
                o_data      <= cap_buf;
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_task_8_deserializer.sv
// Randomised scoreboard bench for task_8_deserializer; a frame-level reference model
// predicts every valid/err pulse, which an independent monitor pops and compares.
module tb_task_8_deserializer;

    localparam int NB    = 16;
    localparam int DW    = 8;
    localparam int GT    = 4;
    localparam int CW    = 16;
    localparam int FLATW = NB * DW;

    logic          i_clk;
    logic          i_rst_n;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic [DW-1:0] o_data [NB];
    logic          o_valid;
    logic          o_busy;
    logic          o_err;
    logic [CW-1:0] o_frame_cnt;

    task_8_deserializer #(
        .NUM_BYTES  (NB),
        .DATA_W     (DW),
        .GAP_TIMEOUT(GT),
        .CNT_W      (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .o_frame_cnt(o_frame_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int edge_cnt = 0;
    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        bit               is_err;
        int               cycle;
        logic [FLATW-1:0] data;
        int               cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: the bytes of the frame in progress and frame history.
    logic [DW-1:0]    cur_q[$];
    int               idle_cnt   = 0;
    int               frames     = 0;
    logic [FLATW-1:0] last_frame = '0;

    task automatic checkOutput(input string name, input logic [FLATW-1:0] act,
                               input logic [FLATW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [FLATW-1:0] flatOut();
        logic [FLATW-1:0] f;
        for (int i = 0; i < NB; i++) f[i*DW +: DW] = o_data[i];
        return f;
    endfunction

    task automatic modelStep(input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            cur_q.push_back(d);
            idle_cnt = 0;
            if (cur_q.size() == NB) begin
                for (int i = 0; i < NB; i++) last_frame[i*DW +: DW] = cur_q[i];
                frames       = (frames + 1) % (1 << CW);
                e.is_err     = 1'b0;
                e.cycle      = edge_cnt + 1;
                e.data       = last_frame;
                e.cnt        = frames;
                exp_q.push_back(e);
                cur_q.delete();
            end
        end else if (cur_q.size() != 0 && GT > 0) begin
            idle_cnt++;
            if (idle_cnt == GT) begin
                e.is_err = 1'b1;
                e.cycle  = edge_cnt;
                e.data   = last_frame;
                e.cnt    = frames;
                exp_q.push_back(e);
                cur_q.delete();
                idle_cnt = 0;
            end
        end
    endtask

    // Drive one cycle of input, let the edge take it, then update the model.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge i_clk);
        #1;
        if (i_rst_n) modelStep(v, d);
        checkOutput("busy", {127'd0, o_busy}, {127'd0, (cur_q.size() != 0)});
    endtask

    task automatic sendFrame(input logic [DW-1:0] base);
        for (int i = 0; i < NB; i++) applyStimulus(1'b1, base + DW'(i));
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_data"}, flatOut(), '0);
        checkOutput({name, "_flags"}, {125'd0, o_valid, o_busy, o_err}, '0);
        checkOutput({name, "_cnt"}, {112'd0, o_frame_cnt}, '0);
    endtask

    exp_t mon_e;
    always @(negedge i_clk) begin
        if (i_rst_n && (o_valid || o_err)) begin
            checkOutput("valid_err_exclusive", {127'd0, o_valid & o_err}, '0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b expected none at edge %0d",
                         o_valid, o_err, edge_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse_kind", {127'd0, o_err}, {127'd0, mon_e.is_err});
                checkOutput("pulse_cycle", FLATW'(edge_cnt), FLATW'(mon_e.cycle));
                checkOutput("frame_data", flatOut(), mon_e.data);
                if (!mon_e.is_err)
                    checkOutput("frame_cnt", {112'd0, o_frame_cnt}, FLATW'(mon_e.cnt));
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        #12;
        checkReset("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (20) applyStimulus(1'b0, '0);

        sendFrame(8'h00);
        repeat (3) applyStimulus(1'b0, '0);

        sendFrame(8'h10);
        sendFrame(8'h20);
        sendFrame(8'h30);
        repeat (3) applyStimulus(1'b0, '0);

        for (int i = 0; i < NB; i++) begin
            applyStimulus(1'b1, 8'h60 + 8'(i));
            if (i == 4 || i == 9) repeat (3) applyStimulus(1'b0, '0);
        end
        repeat (2) applyStimulus(1'b0, '0);

        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h70 + 8'(i));
        repeat (GT) applyStimulus(1'b0, '0);
        sendFrame(8'hA0);
        repeat (2) applyStimulus(1'b0, '0);

        // Random frames with random stalls, some long enough to abort.
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < NB; b++) begin
                applyStimulus(1'b1, 8'($urandom));
                if ($urandom_range(0, 4) == 0)
                    repeat ($urandom_range(1, 5)) applyStimulus(1'b0, '0);
            end
        end
        repeat (GT + 2) applyStimulus(1'b0, '0);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h90 + 8'(i));
        #2;
        i_rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        cur_q.delete();
        idle_cnt   = 0;
        frames     = 0;
        last_frame = '0;
        applyStimulus(1'b0, '0);
        i_rst_n = 1'b1;
        sendFrame(8'h50);
        repeat (5) applyStimulus(1'b0, '0);

        checkOutput("pending_expectations", FLATW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
